pipe_subtractor: RTL
====================

Name: pipe_subtractor

Overview:
- Pipelined ripple-borrow subtractor D = A - B, the inverse-operation companion to the team's pipelined ripple-carry adder.
- Operands are split into slices of SLICE bits; each slice is one pipeline stage with a registered borrow into the next stage.
- Input skew and output deskew registers align all difference bits, so one operand pair enters per cycle and one fully aligned result leaves per cycle.
- Sits in the arithmetic datapath beside the adder and shares its bench style and tap-out debug convention.

Parameters:
- WIDTH, 4, operand and result width in bits; must be a multiple of SLICE.
- SLICE, 1, bits per pipeline stage; STAGES = WIDTH/SLICE (derived, not overridable).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  pipeline advance enable; 0 freezes every register.
- in_valid  input  1  A/B valid this cycle.
- A  input  WIDTH  minuend, unsigned or two's complement.
- B  input  WIDTH  subtrahend.
- out_valid  output  1  D/bout/ovf valid.
- D  output  WIDTH  A - B mod 2^WIDTH.
- bout  output  1  final borrow: 1 iff A < B unsigned.
- ovf  output  1  signed overflow of A - B.
- tb  output  STAGES-1  registered inter-stage borrows (tap k = borrow out of stage k), debug only.

Behaviour:
- Reset (reset=0, asynchronous): every pipeline, skew, deskew and valid register, and all outputs, clear to 0 immediately. Release is synchronous to the next clk edge.
- Stage k (0..STAGES-1) computes the slice [k*SLICE +: SLICE] of A - B - borrow_in. The result slice and borrow_out are registered.
- Stage 0 borrow_in is 0.
- Input skew: slice k of A and B is delayed k registers before reaching stage k.
- Output deskew: the stage-k result is delayed STAGES-1-k registers.
- Latency: operands sampled at edge n with en=1 appear on D/bout/ovf/out_valid after edge n+STAGES-1. That is STAGES register levels, 4 cycles at the default parameters.
- Throughput: one operand pair per enabled cycle. There are no bubbles except those caused by in_valid=0.
- in_valid travels through a STAGES-deep valid shift register beside the data.
- When in_valid=0, data registers still advance. Their contents are don't-care, but out_valid must be 0 for those slots.
- en=0: all registers, including the valid chain, hold. Outputs stay stable, and A/B/in_valid are ignored that cycle.
- bout = registered borrow out of the last stage, aligned with D.
- ovf = (A[msb] != B[msb]) && (D[msb] != A[msb]), computed from msb values delayed to the output stage and aligned with D.
- Reset asserted mid-stream: in-flight results are discarded and out_valid=0 on the following cycles until new valid operands propagate.
- Simultaneous en=0 and reset=0: reset wins.
- No backpressure beyond en. The consumer must accept each out_valid=1 cycle.

Decomposition:
- Shared package arith_pkg:
  - function stages(width, slice);
  - constant DEFAULT_WIDTH=4;
  - constant DEFAULT_SLICE=1;
  - reused by the adder.
- One sub-module, pipe_sub_slice:
  - SLICE-bit subtract-with-borrow, registered diff and borrow_out, en, async active-low reset.
  - The top instantiates STAGES copies and owns the skew/deskew and valid chains.

Test Plan:
- Reset held 0 for half a cycle, then released -> D=0, bout=0, ovf=0, out_valid=0, tb=0 while reset is 0 and until the first valid result.
- A=15, B=15, in_valid=1 for one cycle -> exactly 4 cycles later out_valid=1, D=0, bout=0, ovf=0, then out_valid=0.
- Back-to-back stream (0,1), (8,1), (7,15), (3,3), (15,0) -> consecutive outputs:
  - D=15 bout=1 ovf=0
  - D=7 bout=0 ovf=1
  - D=8 bout=1 ovf=1
  - D=0 bout=0 ovf=0
  - D=15 bout=0 ovf=0
  - out_valid high 5 cycles.
- Same stream with en=0 for 2 cycles after the 2nd operand -> outputs identical in order and value, delayed 2 cycles; D/out_valid hold steady during the stall.
- Stream of 4 valid pairs, reset pulsed low after the 2nd output -> output and tb registers clear asynchronously; no further out_valid until new operands are applied; then correct latency resumes.
- WIDTH=8, SLICE=2, A=0x00, B=0x01 then A=0x80, B=0x7F -> after 4 cycles D=0xFF bout=1 ovf=0, next cycle D=0x01 bout=0 ovf=1.

Source files
------------

// File: rtl/arith_pkg.sv
// arith_pkg: shared widths and stage-count helper for the pipelined adder and subtractor
package arith_pkg;
  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_SLICE = 1;
  function automatic int stages(input int width, input int slice);
    return width / slice;
  endfunction
endpackage

// File: rtl/pipe_sub_slice.sv
// pipe_sub_slice: registered SLICE-bit a-b-bin; ports clk, reset (async low), en, a, b, bin -> d, bout
module pipe_sub_slice
  import arith_pkg::*;
#(
  parameter int SLICE = DEFAULT_SLICE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             bin,
  output logic [SLICE-1:0] d,
  output logic             bout
);
  logic [SLICE:0] r;
  assign r = {1'b0, a} - {1'b0, b} - {{SLICE{1'b0}}, bin};
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      d    <= '0;
      bout <= 1'b0;
    end else if (en) begin
      d    <= r[SLICE-1:0];
      bout <= r[SLICE];
    end
endmodule

// File: rtl/pipe_subtractor.sv
// pipe_subtractor: pipelined ripple-borrow D=A-B; ports clk, reset (async low), en, in_valid, A, B -> out_valid, D, bout, ovf, tb
module pipe_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SLICE = DEFAULT_SLICE
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              en,
  input  logic                              in_valid,
  input  logic [WIDTH-1:0]                  A,
  input  logic [WIDTH-1:0]                  B,
  output logic                              out_valid,
  output logic [WIDTH-1:0]                  D,
  output logic                              bout,
  output logic                              ovf,
  output logic [stages(WIDTH, SLICE)-2:0]   tb
);
  localparam int STAGES = stages(WIDTH, SLICE);
  logic [STAGES:0]   bw;
  logic [STAGES-1:0] vr;
  logic [1:0]        mc [STAGES];
  assign bw[0] = 1'b0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      vr <= '0;
      for (int i = 0; i < STAGES; i++) mc[i] <= '0;
    end else if (en) begin
      vr    <= (vr << 1) | STAGES'(in_valid);
      mc[0] <= {A[WIDTH-1], B[WIDTH-1]};
      for (int i = 1; i < STAGES; i++) mc[i] <= mc[i-1];
    end
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    logic [2*SLICE-1:0] opd;
    logic [SLICE-1:0]   q;
    if (k == 0) begin : g_in
      assign opd = {A[0 +: SLICE], B[0 +: SLICE]};
    end else begin : g_sk
      logic [2*SLICE-1:0] sk [k];
      always_ff @(posedge clk or negedge reset)
        if (!reset) begin
          for (int i = 0; i < k; i++) sk[i] <= '0;
        end else if (en) begin
          sk[0] <= {A[k*SLICE +: SLICE], B[k*SLICE +: SLICE]};
          for (int i = 1; i < k; i++) sk[i] <= sk[i-1];
        end
      assign opd = sk[k-1];
    end
    pipe_sub_slice #(.SLICE(SLICE)) u_slice (
      .clk  (clk),
      .reset(reset),
      .en   (en),
      .a    (opd[2*SLICE-1:SLICE]),
      .b    (opd[SLICE-1:0]),
      .bin  (bw[k]),
      .d    (q),
      .bout (bw[k+1])
    );
    if (k == STAGES - 1) begin : g_out
      assign D[k*SLICE +: SLICE] = q;
    end else begin : g_dk
      logic [SLICE-1:0] dk [STAGES-1-k];
      always_ff @(posedge clk or negedge reset)
        if (!reset) begin
          for (int i = 0; i < STAGES - 1 - k; i++) dk[i] <= '0;
        end else if (en) begin
          dk[0] <= q;
          for (int i = 1; i < STAGES - 1 - k; i++) dk[i] <= dk[i-1];
        end
      assign D[k*SLICE +: SLICE] = dk[STAGES-2-k];
    end
  end
  assign out_valid = vr[STAGES-1];
  assign bout      = bw[STAGES];
  assign tb        = bw[STAGES-1:1];
  assign ovf       = (mc[STAGES-1][1] != mc[STAGES-1][0]) && (D[WIDTH-1] != mc[STAGES-1][1]);
endmodule
